chipmunk_player: RTL and testbench

Playback sequencer between the flash Avalon-MM read port and the audio codec write port in the chipmunks task. It fetches 32-bit words from flash, splits each into two signed 16-bit samples (low half first), and feeds them to the codec. A mode input selects normal, chipmunk (2x, drop samples) or slow (0.5x, repeat samples) playback. Playback loops over a fixed word range.

---
 rtl/chipmunk_player.sv | 195 +++++++++++++++++++
 tb/tb_chipmunk_player.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chipmunk_player.sv
// chipmunk_player
//
// Playback sequencer between the flash Avalon-MM read port and the audio
// codec write port. It reads one 32-bit word at a time from flash, splits it
// into two signed 16-bit samples (low half first) and hands them to the codec.
// The sample sequence per word depends on the mode latched at the start of
// that word:
//   00 / 11 normal   : lo, hi          (2 writes)
//   01      chipmunk : lo              (1 write, 2x speed)
//   10      slow     : lo, lo, hi, hi  (4 writes, 0.5x speed)
// Playback loops over word addresses 0 .. NUM_WORDS-1.
//
// Optional feature (compile-time macro SAMPLE_SCALE_EN): when defined, every
// sample is arithmetically shifted right by 6 before reaching the codec.
// When undefined, samples pass through unmodified.
//
// Handshakes:
//   Flash: flash_mem_read is held with a stable address until a cycle with
//   flash_mem_waitrequest=0 accepts it; the word is then taken from the first
//   flash_mem_readdatavalid pulse. Exactly one read is ever outstanding, and
//   readdatavalid outside that window is ignored.
//   Codec: write_s rises the cycle after write_ready is seen high, stays high
//   with data held until write_ready is seen low, then stays low for at least
//   one cycle before the next sample.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   play, mode                 run level and playback speed select
//   flash_mem_*                Avalon-MM read master (byteenable fixed 4'hF)
//   write_ready, write_s       codec FIFO ready / write strobe
//   writedata_left/right       sample to codec (both channels identical)
//   busy                       high in every state except IDLE
//   wrap                       one-cycle pulse when the address wraps to 0
//   dbg_state_o                current FSM state, for observation
module chipmunk_player #(
    parameter logic [22:0] NUM_WORDS = 23'd1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic [1:0]  mode,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    input  logic        write_ready,
    output logic        write_s,
    output logic [15:0] writedata_left,
    output logic [15:0] writedata_right,
    output logic        busy,
    output logic        wrap,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        WAIT_VALID = 3'd2,
        WAIT_READY = 3'd3,
        WRITE      = 3'd4,
        RELEASE    = 3'd5
    } state_t;

    localparam logic [22:0] LAST_ADDR = NUM_WORDS - 23'd1;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [1:0]  k_q;
    logic [31:0] word_q;
    logic [22:0] addr_q;
    logic [22:0] addr_d;
    logic        read_q;
    logic        write_q;
    logic        wrap_q;
    logic [15:0] data_q;

    // Index of the last sample of a word for a given mode.
    function automatic logic [1:0] last_k(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'b01:   r = 2'd0;
            2'b10:   r = 2'd3;
            default: r = 2'd1;
        endcase
        return r;
    endfunction

    // Sample k of word w under mode m, scaled when the feature is built in.
    function automatic logic [15:0] pick(input logic [31:0] w,
                                         input logic [1:0]  m,
                                         input logic [1:0]  k);
        logic        hi;
        logic [15:0] raw;
        logic [15:0] res;
        case (m)
            2'b01:   hi = 1'b0;
            2'b10:   hi = k[1];   // lo, lo, hi, hi
            default: hi = k[0];   // lo, hi
        endcase
        raw = hi ? w[31:16] : w[15:0];
`ifdef SAMPLE_SCALE_EN
        res = $signed(raw) >>> 6;
`else
        res = raw;
`endif
        return res;
    endfunction

    assign addr_d = (addr_q == LAST_ADDR) ? 23'd0 : addr_q + 23'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            k_q     <= 2'd0;
            word_q  <= 32'd0;
            addr_q  <= 23'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wrap_q  <= 1'b0;
            data_q  <= 16'd0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (play) begin
                        mode_q  <= mode;
                        read_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!flash_mem_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= WAIT_VALID;
                    end
                end
                WAIT_VALID: begin
                    if (flash_mem_readdatavalid) begin
                        word_q  <= flash_mem_readdata;
                        k_q     <= 2'd0;
                        // First sample of every mode is the low half.
                        data_q  <= pick(flash_mem_readdata, mode_q, 2'd0);
                        state_q <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (write_ready) begin
                        write_q <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!write_ready) begin
                        write_q <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (k_q != last_k(mode_q)) begin
                        k_q     <= k_q + 2'd1;
                        data_q  <= pick(word_q, mode_q, k_q + 2'd1);
                        state_q <= WAIT_READY;
                    end else begin
                        // Word finished: the address only moves here.
                        addr_q <= addr_d;
                        wrap_q <= (addr_q == LAST_ADDR);
                        k_q    <= 2'd0;
                        if (play) begin
                            mode_q  <= mode;
                            read_q  <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign write_s              = write_q;
    assign writedata_left       = data_q;
    assign writedata_right      = data_q;
    assign busy                 = (state_q != IDLE);
    assign wrap                 = wrap_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_chipmunk_player.sv
`timescale 1ns/1ps
module tb_chipmunk_player;

    localparam int NW = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = 32'd0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic        write_ready = 1'b0;
    logic        write_s;
    logic [15:0] writedata_left;
    logic [15:0] writedata_right;
    logic        busy;
    logic        wrap;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    chipmunk_player #(.NUM_WORDS(23'd4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .play                    (play),
        .mode                    (mode),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .write_ready             (write_ready),
        .write_s                 (write_s),
        .writedata_left          (writedata_left),
        .writedata_right         (writedata_right),
        .busy                    (busy),
        .wrap                    (wrap),
        .dbg_state_o             (dbg_state)
    );

    // ---------------- check helper ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem [NW];
    logic [15:0] exp_q[$];
    int          ref_addr  = 0;
    int          exp_wraps = 0;

    function automatic logic [15:0] scale(input logic [15:0] s);
        logic [15:0] r;
`ifdef SAMPLE_SCALE_EN
        r = $signed(s) >>> 6;
`else
        r = s;
`endif
        return r;
    endfunction

    // Append the samples one word produces, then step the model address.
    task automatic expect_words(input int n, input logic [1:0] m);
        logic [15:0] lo;
        logic [15:0] hi;
        for (int i = 0; i < n; i++) begin
            lo = scale(mem[ref_addr][15:0]);
            hi = scale(mem[ref_addr][31:16]);
            case (m)
                2'b01: exp_q.push_back(lo);
                2'b10: begin
                    exp_q.push_back(lo); exp_q.push_back(lo);
                    exp_q.push_back(hi); exp_q.push_back(hi);
                end
                default: begin
                    exp_q.push_back(lo); exp_q.push_back(hi);
                end
            endcase
            if (ref_addr == NW - 1) exp_wraps++;
            ref_addr = (ref_addr + 1) % NW;
        end
    endtask

    // ---------------- flash responder ----------------
    int          ws_cfg = 0;
    int          lat_cfg = 1;
    bit          flash_rand = 1'b0;
    bit          spurious = 1'b0;
    int          ws_left = 0;
    int          lat_left = 0;
    bit          in_req = 1'b0;
    bit          addr_moved = 1'b0;
    bit          overlap = 1'b0;
    logic [22:0] req_addr = 23'd0;
    int          fetch_cnt = 0;
    int          exp_fetch_addr = 0;

    always @(negedge clk) begin
        flash_mem_readdatavalid = 1'b0;
        if (reset) begin
            in_req = 1'b0;
            lat_left = 0;
            flash_mem_waitrequest = 1'b0;
            exp_fetch_addr = 0;
        end else if (lat_left > 0) begin
            if (flash_mem_read) overlap = 1'b1;
            lat_left--;
            if (lat_left == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = mem[req_addr[1:0]];
                check("single_outstanding_read", {31'd0, overlap}, 32'd0);
                overlap = 1'b0;
            end
        end else if (flash_mem_read) begin
            if (!in_req) begin
                in_req = 1'b1;
                req_addr = flash_mem_address;
                addr_moved = 1'b0;
                ws_left = flash_rand ? int'($urandom_range(0, 3)) : ws_cfg;
            end
            if (flash_mem_address != req_addr) addr_moved = 1'b1;
            if (ws_left > 0) begin
                flash_mem_waitrequest = 1'b1;
                ws_left--;
            end else begin
                flash_mem_waitrequest = 1'b0;
                in_req = 1'b0;
                lat_left = flash_rand ? int'($urandom_range(1, 4)) : lat_cfg;
                check("fetch_addr", {9'd0, flash_mem_address}, exp_fetch_addr);
                check("addr_stable_in_fetch", {31'd0, addr_moved}, 32'd0);
                exp_fetch_addr = (exp_fetch_addr + 1) % NW;
                fetch_cnt++;
            end
        end else begin
            flash_mem_waitrequest = 1'($urandom_range(0, 1));
            if (spurious && $urandom_range(0, 5) == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = $urandom;
            end
        end
    end

    // ---------------- codec responder ----------------
    // 0 prompt, 1 random, 2 hold low, 3 hold high
    int codec_mode = 0;

    always @(negedge clk) begin
        case (codec_mode)
            0: write_ready = !write_s;
            1: begin
                if (write_s) write_ready = ($urandom_range(0, 2) == 0) ? write_ready : 1'b0;
                else         write_ready = 1'($urandom_range(0, 1));
            end
            2: write_ready = 1'b0;
            default: write_ready = 1'b1;
        endcase
    end

    // ---------------- write / wrap scoreboard ----------------
    logic        prev_ws = 1'b0;
    logic        prev_wrap = 1'b0;
    logic [22:0] prev_addr = 23'd0;
    logic [15:0] held = 16'd0;
    logic [15:0] e = 16'd0;
    bit          held_bad = 1'b0;
    int          low_cnt = 100;
    int          write_cnt = 0;
    int          wrap_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_ws = 1'b0; prev_wrap = 1'b0; prev_addr = 23'd0; low_cnt = 100;
        end else begin
            if (write_s && !prev_ws) begin
                write_cnt++;
                check("write_low_gap", {31'd0, low_cnt >= 1}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {16'd0, writedata_left}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_left", {16'd0, writedata_left}, {16'd0, e});
                    check("sample_right", {16'd0, writedata_right}, {16'd0, e});
                end
                held = writedata_left;
                held_bad = 1'b0;
            end else if (write_s) begin
                if (writedata_left != held || writedata_right != held) held_bad = 1'b1;
            end
            if (!write_s && prev_ws) check("data_held_during_write", {31'd0, held_bad}, 32'd0);
            if (write_s) low_cnt = 0; else low_cnt++;
            if (wrap) begin
                wrap_cnt++;
                check("wrap_at_3_to_0", {30'd0, prev_addr == 23'(NW - 1), flash_mem_address == 23'd0}, 32'd3);
                check("wrap_one_cycle", {31'd0, prev_wrap}, 32'd0);
            end
            prev_ws = write_s; prev_wrap = wrap; prev_addr = flash_mem_address;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        while ((busy || write_s) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic play_words(input int n);
        int target = fetch_cnt + n;
        int c = 0;
        play = 1'b1;
        while (fetch_cnt < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        play = 1'b0;
        check("fetch_count", fetch_cnt, target);
        wait_idle();
    endtask

    // ---------------- directed + random sequence ----------------
    int t_fetch;
    int t_write;
    int w0;
    int w_save;
    int n;
    bit ws_seen;
    bit data_bad;
    logic [15:0] first_exp;

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read", {31'd0, flash_mem_read}, 32'd0);
        check("rst_write_s", {31'd0, write_s}, 32'd0);
        check("rst_address", {9'd0, flash_mem_address}, 32'd0);
        check("rst_data", {writedata_left, writedata_right}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        check("rst_byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
        reset = 1'b0;

        // Normal word, waitrequest 2 cycles, valid 3 cycles after accept.
        mem[0] = 32'h2222_1111; ws_cfg = 2; lat_cfg = 3; codec_mode = 0; mode = 2'b00;
        expect_words(1, 2'b00);
        t_fetch = -1; t_write = -1;
        play = 1'b1;
        for (int c = 0; c < 300 && t_write < 0; c++) begin
            @(negedge clk);
            if (flash_mem_read && t_fetch < 0) t_fetch = c;
            if (write_s && t_write < 0) t_write = c;
            if (fetch_cnt >= 1) play = 1'b0;
        end
        play = 1'b0;
        check("first_write_latency", t_write - t_fetch, 1 + 2 + 3 + 1);
        wait_idle();
        check("normal_all_written", exp_q.size(), 0);
        check("normal_addr_after", {9'd0, flash_mem_address}, 32'd1);

        // Chipmunk: two words, one write each.
        mode = 2'b01; mem[1] = 32'hBBBB_AAAA; mem[2] = 32'hDDDD_CCCC;
        w0 = write_cnt;
        expect_words(2, 2'b01);
        play_words(2);
        check("chipmunk_write_count", write_cnt - w0, 2);
        check("chipmunk_all_written", exp_q.size(), 0);

        // Slow: one word, four writes; address 3 wraps to 0.
        mode = 2'b10; mem[3] = 32'h0002_0001;
        w0 = write_cnt;
        expect_words(1, 2'b10);
        play_words(1);
        check("slow_write_count", write_cnt - w0, 4);
        check("slow_addr_wrapped", {9'd0, flash_mem_address}, 32'd0);

        // Sign-sensitive word (differs between scaled and unscaled builds).
        mode = 2'b00; mem[0] = 32'h1FC0_8000;
        expect_words(1, 2'b00);
        play_words(1);
        check("scale_word_written", exp_q.size(), 0);

        // Five random words, random handshakes, spurious valids, crosses the wrap.
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        flash_rand = 1'b1; spurious = 1'b1; codec_mode = 1; mode = 2'b00;
        expect_words(5, 2'b00);
        play_words(5);
        check("random_normal_written", exp_q.size(), 0);

        // Mode change during a word applies only from the next word.
        mode = 2'b00;
        expect_words(1, 2'b00);
        expect_words(1, 2'b01);
        w0 = write_cnt;
        n = fetch_cnt + 2;
        play = 1'b1;
        for (int c = 0; c < 2000 && write_cnt == w0; c++) @(negedge clk);
        mode = 2'b01;
        for (int c = 0; c < 3000 && fetch_cnt < n; c++) @(negedge clk);
        play = 1'b0;
        wait_idle();
        check("mode_change_written", exp_q.size(), 0);
        check("mode_change_count", write_cnt - w0, 3);

        // Random segments: random mode (11 acts as normal), random length.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NW; i++) mem[i] = $urandom;
            mode = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 5);
            expect_words(n, mode);
            play_words(n);
            check("random_segment_written", exp_q.size(), 0);
        end

        // Codec not ready for 50 cycles: no strobe, data held.
        flash_rand = 1'b0; spurious = 1'b0; ws_cfg = 1; lat_cfg = 2;
        codec_mode = 2; mode = 2'b00;
        expect_words(1, 2'b00);
        first_exp = exp_q[0];
        n = fetch_cnt + 1;
        play = 1'b1;
        for (int c = 0; c < 500 && fetch_cnt < n; c++) @(negedge clk);
        play = 1'b0;
        repeat (10) @(negedge clk);
        ws_seen = 1'b0; data_bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (write_s) ws_seen = 1'b1;
            if (writedata_left != first_exp) data_bad = 1'b1;
        end
        check("stall_no_write_s", {31'd0, ws_seen}, 32'd0);
        check("stall_data_held", {31'd0, data_bad}, 32'd0);
        codec_mode = 0;
        wait_idle();
        check("stall_all_written", exp_q.size(), 0);

        // Reset while in WRITE.
        codec_mode = 3; mode = 2'b00;
        w_save = exp_wraps;
        expect_words(1, 2'b00);
        play = 1'b1;
        for (int c = 0; c < 500 && !write_s; c++) @(negedge clk);
        play = 1'b0;
        check("reset_test_write_seen", {31'd0, write_s}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        ref_addr = 0;
        exp_wraps = w_save;
        @(negedge clk);
        check("midwrite_rst_write_s", {31'd0, write_s}, 32'd0);
        check("midwrite_rst_read", {31'd0, flash_mem_read}, 32'd0);
        check("midwrite_rst_address", {9'd0, flash_mem_address}, 32'd0);
        check("midwrite_rst_busy", {31'd0, busy}, 32'd0);
        check("midwrite_rst_data", {16'd0, writedata_left}, 32'd0);
        reset = 1'b0;
        codec_mode = 0;

        // Restart after reset begins again at address 0.
        mem[0] = 32'h5A5A_A5A5;
        expect_words(1, 2'b00);
        play_words(1);
        check("restart_written", exp_q.size(), 0);
        check("restart_addr_after", {9'd0, flash_mem_address}, 32'd1);
        check("wrap_pulse_count", wrap_cnt, exp_wraps);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
